// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared mips32 constants for the MEM stage
package mips_defs;

  localparam int CTL_MEMREAD  = 0;
  localparam int CTL_MEMWRITE = 1;
  localparam int CTL_REGWRITE = 2;
  localparam int CTL_MEMTOREG = 3;
  localparam int CTL_LINK     = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUSTO    = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  // Reserved size code 11 falls into the word case.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane enables, store replication, load lane select and extension
module mem_align
  import mips_defs::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = rdata[{addr_lo, 3'b000} +: 8];
    lane_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be      = 4'b1111;
    wdata   = st_data;
    ld_data = rdata;
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{is_signed & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{is_signed & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - mips32 MEM stage: data-memory req/ack access, stall and MEM/WB register
module mem_stage
  import mips_defs::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validIn,
  input  logic [0:4]  controlIn,
  input  logic [1:0]  sizeIn,
  input  logic        signedIn,
  input  logic [31:0] pcIn,
  input  logic [31:0] aluResultIn,
  input  logic [31:0] rtValueIn,
  input  logic [4:0]  destRegIn,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWData,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic        stall,
  output logic        validOut,
  output logic        regWriteOut,
  output logic        memToRegOut,
  output logic        linkOut,
  output logic [31:0] pcOut,
  output logic [31:0] aluResultOut,
  output logic [31:0] memDataOut,
  output logic [4:0]  destRegOut,
  output logic [1:0]  excOut
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        valid_q, valid_d, reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d, link_q, link_d;
  logic [31:0] pc_q, pc_d, alu_q, alu_d, mem_data_q, mem_data_d;
  logic [4:0]  dest_q, dest_d;
  logic [1:0]  exc_q, exc_d;

  logic        is_write, is_read, mem_op, misalign, in_access, timeout, ack;
  logic [31:0] ld_data;

  mem_align u_align (
    .size      (sizeIn),
    .addr_lo   (aluResultIn[1:0]),
    .is_signed (signedIn),
    .st_data   (rtValueIn),
    .rdata     (memRData),
    .be        (memBe),
    .wdata     (memWData),
    .ld_data   (ld_data)
  );

  assign is_write  = controlIn[CTL_MEMWRITE];
  assign is_read   = controlIn[CTL_MEMREAD] & ~is_write;
  assign mem_op    = validIn & (controlIn[CTL_MEMREAD] | is_write);
  assign misalign  = mem_op & is_misaligned(sizeIn, aluResultIn[1:0]);
  assign in_access = (state_q == ST_ACCESS);
  assign timeout   = in_access & ~memAck & (cnt_q == CNT_MAX);

  // Gated by rst so the bus and hazard unit see the abort without waiting for a clock.
  assign memReq  = rst & ((~in_access & mem_op & ~misalign) | in_access);
  assign memWe   = memReq & is_write;
  assign memAddr = {aluResultIn[31:2], 2'b00};
  assign ack     = memReq & memAck;
  assign stall   = memReq & ~memAck & ~timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE:   if (mem_op && !misalign && !memAck) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (memAck || timeout) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    link_d       = link_q;
    pc_d         = pc_q;
    alu_d        = alu_q;
    mem_data_d   = mem_data_q;
    dest_d       = dest_q;
    exc_d        = exc_q;
    if (stall) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else begin
      valid_d      = validIn;
      reg_write_d  = validIn & controlIn[CTL_REGWRITE] & ~misalign & ~timeout;
      mem_to_reg_d = controlIn[CTL_MEMTOREG];
      link_d       = controlIn[CTL_LINK];
      pc_d         = pcIn;
      alu_d        = aluResultIn;
      dest_d       = destRegIn;
      mem_data_d   = (ack && is_read) ? ld_data : 32'h0;
      exc_d        = misalign ? EXC_MISALIGN : (timeout ? EXC_BUSTO : EXC_NONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      pc_q         <= RESET_PC;
      alu_q        <= 32'h0;
      mem_data_q   <= 32'h0;
      dest_q       <= 5'h0;
      exc_q        <= EXC_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      link_q       <= link_d;
      pc_q         <= pc_d;
      alu_q        <= alu_d;
      mem_data_q   <= mem_data_d;
      dest_q       <= dest_d;
      exc_q        <= exc_d;
    end
  end

  assign validOut     = valid_q;
  assign regWriteOut  = reg_write_q;
  assign memToRegOut  = mem_to_reg_q;
  assign linkOut      = link_q;
  assign pcOut        = pc_q;
  assign aluResultOut = alu_q;
  assign memDataOut   = mem_data_q;
  assign destRegOut   = dest_q;
  assign excOut       = exc_q;

endmodule
